friscv_ram_hs: RTL and testbench

Parametrised single-clock RAM with per-byte write strobes and a valid/ready read channel. Read data is staged in a 2-entry output buffer, so downstream back-pressure stalls reads without losing data. Optional same-cycle read-during-write forwarding. Replaces the bare simple-dual-port RAM wherever a memory sits behind a handshaked pipeline stage, such as cache data arrays or register-like storage fed by stalling consumers.

---
 rtl/friscv_ram_hs.sv | 64 ++++++
 tb/tb_friscv_ram_hs.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/friscv_ram_hs.sv
// friscv_ram_hs: byte-strobed single-clock RAM whose reads land in a 2-entry
// handshaked output buffer, so a stalled consumer never loses read data.
module friscv_ram_hs #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int INIT       = 0,
   parameter int BYPASS_EN  = 1
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic                    rd_valid,
   output logic                    rd_ready,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic                    rdata_valid,
   input  logic                    rdata_ready,
   output logic [DATA_WIDTH-1:0]   rdata
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Power-up contents only; the array is never touched by reset.
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: {DATA_WIDTH{(INIT != 0) ? 1'b0 : 1'bx}}};
   logic [DATA_WIDTH-1:0] data_q [2];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [1:0]            occ;
   logic                  wr_ptr, rd_ptr, push, pop, hit;

   assign rd_ready    = aresetn && !occ[1];
   assign rdata_valid = occ != 2'd0;
   assign rdata       = data_q[rd_ptr];
   assign push        = rd_valid && rd_ready;
   assign pop         = rdata_valid && rdata_ready;
   assign hit         = wr_en && (wr_addr == rd_addr);

   for (genvar g = 0; g < NB; g++) begin : g_byte
      assign rd_word[8*g+:8] = (BYPASS_EN != 0 && hit && wr_strb[g]) ? wr_data[8*g+:8] : mem[rd_addr][8*g+:8];
   end

   always_ff @(posedge aclk) begin
      for (int i = 0; i < NB; i++)
         if (wr_en && wr_strb[i]) mem[wr_addr][8*i+:8] <= wr_data[8*i+:8];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         occ       <= 2'd0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         data_q[0] <= '0;
         data_q[1] <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= rd_word;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_friscv_ram_hs.sv
// tb_friscv_ram_hs: directed checks of friscv_ram_hs with forwarding on and off;
// both instances see the same stimulus.
module tb_friscv_ram_hs;
   logic        clk = 1'b0, aresetn = 1'b0;
   logic        wr_en = 1'b0, rd_valid = 1'b0, rdata_ready = 1'b0;
   logic [7:0]  wr_addr = '0, rd_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_strb = '0;
   logic        rd_ready, rdata_valid, rd_ready0, rdata_valid0;
   logic [31:0] rdata, rdata0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   friscv_ram_hs #(.BYPASS_EN(1)) dut (
      .aclk(clk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata));

   friscv_ram_hs #(.BYPASS_EN(0)) dut0 (
      .aclk(clk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .rd_valid(rd_valid), .rd_ready(rd_ready0), .rd_addr(rd_addr),
      .rdata_valid(rdata_valid0), .rdata_ready(rdata_ready), .rdata(rdata0));

   function automatic logic [31:0] pat(input logic [7:0] a);
      return {a, ~a, a ^ 8'h3c, a + 8'd1};
   endfunction

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      rd_valid = 1'b1; rd_addr = a;
      @(negedge clk);
      rd_valid = 1'b0;
   endtask

   task automatic pop1;
      rdata_ready = 1'b1;
      @(negedge clk);
      rdata_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid got %b exp 0", rdata_valid); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 00000000", rdata); end
      aresetn = 1'b1;
      #1;
      checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL release_rd_ready got %b exp 1", rd_ready); end
      @(negedge clk);
      checks++; if (rdata_valid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL release_out got %b/%h exp 0/00000000", rdata_valid, rdata); end
   endtask

   task automatic test_basic;
      wr(8'h10, 32'hdeadbeef, 4'hf);
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", rdata_valid); end
      rd(8'h10);
      checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hdeadbeef) begin errors++; $display("FAIL basic_read got %b/%h exp 1/deadbeef", rdata_valid, rdata); end
      pop1;
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b exp 0", rdata_valid); end
   endtask

   task automatic test_strobe;
      wr(8'h05, 32'h11223344, 4'hf);
      wr(8'h05, 32'haabbccdd, 4'h5);
      wr(8'h05, 32'hffffffff, 4'h0);
      rd(8'h05);
      checks++; if (rdata !== 32'h11bb33dd) begin errors++; $display("FAIL strobe got %h exp 11bb33dd", rdata); end
      pop1;
   endtask

   task automatic test_collision;
      wr(8'h07, 32'h01020304, 4'hf);
      wr_en = 1'b1; wr_addr = 8'h07; wr_data = 32'hcafef00d; wr_strb = 4'hc;
      rd_valid = 1'b1; rd_addr = 8'h07;
      @(negedge clk);
      wr_en = 1'b0; rd_valid = 1'b0;
      checks++; if (rdata !== 32'hcafe0304) begin errors++; $display("FAIL bypass1 got %h exp cafe0304", rdata); end
      checks++; if (rdata0 !== 32'h01020304) begin errors++; $display("FAIL bypass0 got %h exp 01020304", rdata0); end
      pop1;
      rd(8'h07);
      checks++; if (rdata0 !== 32'hcafe0304) begin errors++; $display("FAIL bypass0_followup got %h exp cafe0304", rdata0); end
      checks++; if (rdata !== 32'hcafe0304) begin errors++; $display("FAIL bypass1_followup got %h exp cafe0304", rdata); end
      pop1;
   endtask

   task automatic test_backpressure;
      for (int a = 1; a <= 3; a++) wr(8'(a), 32'ha0000000 | a, 4'hf);
      rd_valid = 1'b1; rd_addr = 8'h01;
      checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", rd_ready); end
      @(negedge clk);
      rd_addr = 8'h02;
      checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %b exp 1", rd_ready); end
      @(negedge clk);
      rd_addr = 8'h03;
      checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", rd_ready); end
      @(negedge clk);
      checks++; if (rd_ready !== 1'b0 || rdata !== 32'ha0000001) begin errors++; $display("FAIL bp_hold got %b/%h exp 0/a0000001", rd_ready, rdata); end
      rdata_ready = 1'b1;
      #1;
      checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL bp_no_comb_ready got %b exp 0", rd_ready); end
      @(negedge clk);
      checks++; if (rd_ready !== 1'b1 || rdata !== 32'ha0000002) begin errors++; $display("FAIL bp_second got %b/%h exp 1/a0000002", rd_ready, rdata); end
      @(negedge clk);
      rd_valid = 1'b0;
      checks++; if (rdata_valid !== 1'b1 || rdata !== 32'ha0000003) begin errors++; $display("FAIL bp_third got %b/%h exp 1/a0000003", rdata_valid, rdata); end
      @(negedge clk);
      rdata_ready = 1'b0;
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", rdata_valid); end
   endtask

   task automatic test_stream;
      for (int a = 0; a < 256; a++) wr(8'(a), pat(8'(a)), 4'hf);
      rdata_ready = 1'b1;
      for (int i = 0; i <= 257; i++) begin
         logic [7:0] p, q;
         p = 8'(i - 1);
         q = 8'(i);
         if (i > 0) begin
            checks++;
            if (rdata_valid !== 1'b1 || rdata !== pat(p) || rd_ready !== 1'b1) begin
               errors++; $display("FAIL stream_%0d got %b/%h/%b exp 1/%h/1", i - 1, rdata_valid, rdata, rd_ready, pat(p));
            end
         end
         rd_valid = i < 257; rd_addr = q;
         @(negedge clk);
      end
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", rdata_valid); end
      rdata_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      rd(8'h09);
      rd(8'h0a);
      checks++; if (rdata_valid !== 1'b1 || rd_ready !== 1'b0 || rdata !== pat(8'h09)) begin errors++; $display("FAIL mid_full got %b/%b/%h exp 1/0/%h", rdata_valid, rd_ready, rdata, pat(8'h09)); end
      #2 aresetn = 1'b0;
      #1;
      checks++; if (rdata_valid !== 1'b0 || rd_ready !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL mid_async got %b/%b/%h exp 0/0/00000000", rdata_valid, rd_ready, rdata); end
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      checks++; if (rd_ready !== 1'b1 || rdata_valid !== 1'b0) begin errors++; $display("FAIL mid_release got %b/%b exp 1/0", rd_ready, rdata_valid); end
      @(negedge clk);
      rd(8'h0a);
      checks++; if (rdata_valid !== 1'b1 || rdata !== pat(8'h0a)) begin errors++; $display("FAIL mid_retained got %b/%h exp 1/%h", rdata_valid, rdata, pat(8'h0a)); end
      pop1;
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL mid_pop got %b exp 0", rdata_valid); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_strobe;
      test_collision;
      test_backpressure;
      test_stream;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
